pipe_scoreboard: RTL and testbench

- Parametrised hazard and forwarding scoreboard for the in-order integer pipeline; it replaces the fixed EX/MEM/WB compare logic.
- Tracks in-flight destination registers through DEPTH post-decode stages, where stage 1 = EX and stage DEPTH = last stage before RF write.
- Per decode operand, returns the youngest producing stage to forward from, and raises a decode stall when that producer's result will not be ready in time.
- Supports variable-latency producers (loads, multi-cycle ops), operands consumed in ID (branches/jr) and an external pipeline freeze.

---
 rtl/pipe_scoreboard.sv | 125 ++++++++++++
 tb/tb_pipe_scoreboard.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_scoreboard.sv
// Hazard/forwarding scoreboard: tracks in-flight destinations over DEPTH post-decode stages.
// Optional stall counter is enabled by defining PIPE_SCOREBOARD_STATS_EN.
module pipe_scoreboard #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned RAW   = 5,
  parameter int unsigned SW    = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           id_valid,
  input  logic [RAW-1:0] id_rs,
  input  logic [RAW-1:0] id_rt,
  input  logic           id_rs_used,
  input  logic           id_rt_used,
  input  logic           id_branch,
  input  logic           id_wr_en,
  input  logic [RAW-1:0] id_rd,
  input  logic [SW-1:0]  id_ready_stage,
  input  logic           ext_stall,
  input  logic           flush,
`ifdef PIPE_SCOREBOARD_STATS_EN
  input  logic           stats_clr,
  output logic [31:0]    stall_cnt,
`endif
  output logic           stall_out,
  output logic [SW-1:0]  fwd_a,
  output logic [SW-1:0]  fwd_b
);

  // Index i holds stage i+1 (index 0 is EX).
  logic [DEPTH-1:0]          valid_q, valid_d;
  logic [DEPTH-1:0][RAW-1:0] rd_q, rd_d;
  logic [DEPTH-1:0][SW-1:0]  rdy_q, rdy_d;

  logic [SW-1:0] rdy_new;
  logic          haz_a, haz_b;

  // Returns {hazard, stage}; scanning oldest-to-youngest lets the youngest match win.
  function automatic logic [SW:0] lookup(input logic [RAW-1:0] src, input logic used);
    logic [SW-1:0] stage;
    logic          hazard;
    stage  = '0;
    hazard = 1'b0;
    if (used && src != '0) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (valid_q[i] && rd_q[i] == src) begin
          stage  = SW'(i + 1);
          hazard = id_branch ? (stage <= rdy_q[i]) : (stage < rdy_q[i]);
        end
      end
    end
    return {hazard, stage};
  endfunction

  always_comb begin
    {haz_a, fwd_a} = lookup(id_rs, id_rs_used);
    {haz_b, fwd_b} = lookup(id_rt, id_rt_used);
    stall_out      = id_valid && (haz_a || haz_b);
  end

  always_comb begin
    rdy_new = id_ready_stage;
    if (id_ready_stage == '0) begin
      rdy_new = SW'(1);
    end else if (id_ready_stage > SW'(DEPTH)) begin
      rdy_new = SW'(DEPTH);
    end
  end

  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    rdy_d   = rdy_q;
    if (!ext_stall) begin
      for (int i = DEPTH - 1; i >= 1; i--) begin
        valid_d[i] = valid_q[i-1];
        rd_d[i]    = rd_q[i-1];
        rdy_d[i]   = rdy_q[i-1];
      end
      if (stall_out || flush || !id_valid) begin
        valid_d[0] = 1'b0;
      end else begin
        valid_d[0] = id_wr_en && (id_rd != '0);
      end
      rd_d[0]  = id_rd;
      rdy_d[0] = rdy_new;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      rd_q    <= '0;
      rdy_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      rdy_q   <= rdy_d;
    end
  end

`ifdef PIPE_SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stats_clr) begin
      stall_cnt_d = '0;
    end else if (stall_out && !ext_stall && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Self-checking bench for pipe_scoreboard: directed vector table, reset corner, random vs model.
// Stall counter checks are included when PIPE_SCOREBOARD_STATS_EN is defined.
module tb_pipe_scoreboard;
  localparam int DEPTH = 3;
  localparam int RAW   = 5;
  localparam int SW    = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           id_valid, id_rs_used, id_rt_used, id_branch, id_wr_en, ext_stall, flush;
  logic [RAW-1:0] id_rs, id_rt, id_rd;
  logic [SW-1:0]  id_ready_stage;
  logic           stall_out;
  logic [SW-1:0]  fwd_a, fwd_b;
`ifdef PIPE_SCOREBOARD_STATS_EN
  logic           stats_clr;
  logic [31:0]    stall_cnt;
  logic [31:0]    m_cnt;
`endif

  always #5 clk = ~clk;

  pipe_scoreboard #(.DEPTH(DEPTH), .RAW(RAW), .SW(SW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_branch(id_branch),
    .id_wr_en(id_wr_en), .id_rd(id_rd), .id_ready_stage(id_ready_stage),
    .ext_stall(ext_stall), .flush(flush),
`ifdef PIPE_SCOREBOARD_STATS_EN
    .stats_clr(stats_clr), .stall_cnt(stall_cnt),
`endif
    .stall_out(stall_out), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  typedef struct {
    bit v; int rs; int rt; bit ru; bit tu; bit br; bit we; int rd; int rdy; bit es; bit fl;
    bit e_st; int e_fa; int e_fb;
  } vec_t;

  typedef struct { bit valid; int rd; int rdy; } ent_t;

  vec_t tbl[$];
  ent_t pipe[$];  // pipe[0] is stage 1
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void add(input bit v, input int rs, input int rt, input bit ru, input bit tu,
                              input bit br, input bit we, input int rd, input int rdy,
                              input bit es, input bit fl, input bit e_st, input int e_fa,
                              input int e_fb);
    vec_t t;
    t = '{v, rs, rt, ru, tu, br, we, rd, rdy, es, fl, e_st, e_fa, e_fb};
    tbl.push_back(t);
  endfunction

  function automatic void model_reset();
    ent_t e;
    e = '{1'b0, 0, 0};
    pipe.delete();
    for (int i = 0; i < DEPTH; i++) pipe.push_back(e);
  endfunction

  // Youngest producer of src; hazard when its value will not be ready for the consumer.
  function automatic void src_lookup(input int src, input bit used, output int stage,
                                     output bit haz);
    stage = 0;
    haz   = 1'b0;
    if (!used || src == 0) return;
    for (int i = 0; i < DEPTH; i++) begin
      if (pipe[i].valid && pipe[i].rd == src) begin
        stage = i + 1;
        haz   = id_branch ? !(stage > pipe[i].rdy) : !(stage >= pipe[i].rdy);
        return;
      end
    end
  endfunction

  function automatic void model_out(output bit st, output int fa, output int fb);
    bit ha, hb;
    src_lookup(int'(id_rs), id_rs_used, fa, ha);
    src_lookup(int'(id_rt), id_rt_used, fb, hb);
    st = id_valid && (ha || hb);
  endfunction

  function automatic void model_clock(input bit st);
    ent_t e;
    int   r;
`ifdef PIPE_SCOREBOARD_STATS_EN
    if (stats_clr) m_cnt = 0;
    else if (st && !ext_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
`endif
    if (ext_stall) return;
    r = int'(id_ready_stage);
    if (r == 0) r = 1;
    if (r > DEPTH) r = DEPTH;
    e.valid = !(st || flush || !id_valid) && id_wr_en && id_rd != 0;
    e.rd    = int'(id_rd);
    e.rdy   = r;
    void'(pipe.pop_back());
    pipe.push_front(e);
  endfunction

  task automatic drive(input vec_t t);
    id_valid = t.v; id_rs = RAW'(t.rs); id_rt = RAW'(t.rt); id_rs_used = t.ru;
    id_rt_used = t.tu; id_branch = t.br; id_wr_en = t.we; id_rd = RAW'(t.rd);
    id_ready_stage = SW'(t.rdy); ext_stall = t.es; flush = t.fl;
  endtask

  task automatic cycle(input bit has_exp, input vec_t t, input int idx);
    bit m_st;
    int m_fa, m_fb;
    @(negedge clk);
    model_out(m_st, m_fa, m_fb);
    chk("stall_out", {31'd0, stall_out}, {31'd0, m_st});
    chk("fwd_a", {29'd0, fwd_a}, m_fa);
    chk("fwd_b", {29'd0, fwd_b}, m_fb);
`ifdef PIPE_SCOREBOARD_STATS_EN
    chk("stall_cnt", stall_cnt, m_cnt);
`endif
    if (has_exp) begin
      chk($sformatf("vec%0d.stall_out", idx), {31'd0, stall_out}, {31'd0, t.e_st});
      chk($sformatf("vec%0d.fwd_a", idx), {29'd0, fwd_a}, t.e_fa);
      chk($sformatf("vec%0d.fwd_b", idx), {29'd0, fwd_b}, t.e_fb);
    end
    @(posedge clk);
    model_clock(m_st);
    #1;
  endtask

  initial begin
    vec_t t;
    rst = 1'b0;
    t = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    drive(t);
`ifdef PIPE_SCOREBOARD_STATS_EN
    stats_clr = 1'b0;
    m_cnt     = 0;
`endif
    model_reset();
    #3;
    chk("reset.stall_out", {31'd0, stall_out}, 32'd0);
    chk("reset.fwd_a", {29'd0, fwd_a}, 32'd0);
    chk("reset.fwd_b", {29'd0, fwd_b}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    //   v  rs rt ru tu br we rd rdy es fl  st fa fb
    add(1, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0,  0, 0, 0);   // add r3
    add(1, 3, 0, 1, 0, 0, 1, 8, 1, 0, 0,  0, 1, 0);   // sub r8 <- r3
    add(1, 3, 0, 1, 0, 0, 0, 0, 1, 0, 0,  0, 2, 0);
    add(1, 3, 0, 1, 0, 0, 0, 0, 1, 0, 0,  0, 3, 0);   // last stage still forwards
    add(1, 3, 0, 1, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 5, 2, 0, 0,  0, 0, 0);   // lw r5
    add(1, 5, 0, 1, 0, 0, 1, 9, 1, 0, 0,  1, 1, 0);   // load-use stall
    add(1, 5, 0, 1, 0, 0, 1, 9, 1, 0, 0,  0, 2, 0);
    add(1, 0, 0, 0, 0, 0, 1, 4, 1, 0, 0,  0, 0, 0);   // add r4
    add(1, 0, 4, 0, 1, 1, 0, 0, 1, 0, 0,  1, 0, 1);   // beq on r4
    add(1, 0, 4, 0, 1, 1, 0, 0, 1, 0, 0,  0, 0, 2);
    add(1, 0, 0, 0, 0, 0, 1, 7, 1, 0, 0,  0, 0, 0);   // r7
    add(1, 0, 0, 0, 0, 0, 1, 6, 1, 0, 0,  0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 7, 1, 0, 0,  0, 0, 0);   // r7 again
    add(1, 7, 0, 1, 1, 0, 0, 0, 1, 0, 0,  0, 1, 0);   // youngest wins, r0 ignored
    add(1, 0, 0, 0, 0, 0, 1, 5, 2, 0, 0,  0, 0, 0);   // lw r5
    add(1, 5, 0, 1, 0, 0, 0, 0, 1, 1, 0,  1, 1, 0);   // frozen
    add(1, 5, 0, 1, 0, 0, 0, 0, 1, 1, 1,  1, 1, 0);   // frozen, flush ignored
    add(1, 5, 0, 1, 0, 0, 0, 0, 1, 1, 0,  1, 1, 0);
    add(1, 5, 0, 1, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0);   // released
    add(1, 5, 0, 1, 0, 0, 0, 0, 1, 0, 0,  0, 2, 0);
    add(1, 0, 0, 0, 0, 0, 1, 10, 7, 0, 0, 0, 0, 0);   // ready clamps to DEPTH
    add(1, 10, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    add(1, 10, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 2, 0);
    add(1, 10, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 3, 0);
    add(1, 0, 0, 0, 0, 0, 1, 11, 0, 0, 1, 0, 0, 0);   // flushed producer
    add(1, 11, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 11, 0, 0, 0, 0, 0, 0);   // ready 0 -> 1
    add(1, 11, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 12, 2, 0, 0, 0, 0, 0);   // lw r12
    add(0, 12, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);   // no instruction: no stall

    foreach (tbl[i]) begin
      drive(tbl[i]);
      cycle(1'b1, tbl[i], i);
    end

    // Async reset mid-cycle with a load-use hazard pending.
    t = '{1, 0, 0, 0, 0, 0, 1, 13, 2, 0, 0, 0, 0, 0};
    drive(t);
    cycle(1'b0, t, 0);
    t = '{1, 13, 13, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    drive(t);
    @(negedge clk);
    chk("pre_rst.stall_out", {31'd0, stall_out}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
`ifdef PIPE_SCOREBOARD_STATS_EN
    m_cnt = 0;
    chk("rst.stall_cnt", stall_cnt, 32'd0);
`endif
    chk("rst.stall_out", {31'd0, stall_out}, 32'd0);
    chk("rst.fwd_a", {29'd0, fwd_a}, 32'd0);
    chk("rst.fwd_b", {29'd0, fwd_b}, 32'd0);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < 3000; n++) begin
      t.v   = ($urandom_range(0, 9) != 0);
      t.rs  = $urandom_range(0, 7);
      t.rt  = $urandom_range(0, 7);
      t.ru  = $urandom_range(0, 1);
      t.tu  = $urandom_range(0, 1);
      t.br  = ($urandom_range(0, 4) == 0);
      t.we  = ($urandom_range(0, 3) != 0);
      t.rd  = $urandom_range(0, 7);
      t.rdy = $urandom_range(0, 5);
      t.es  = ($urandom_range(0, 6) == 0);
      t.fl  = ($urandom_range(0, 9) == 0);
      drive(t);
`ifdef PIPE_SCOREBOARD_STATS_EN
      stats_clr = ($urandom_range(0, 199) == 0);
`endif
      cycle(1'b0, t, n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
